dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//   Write-back, write-allocate, direct-mapped controller that drives the 32-entry cache SRAM
//   (valid/dirty/tag/256-bit line per index).
//   Sits between the CPU MEM stage and data memory.
//   Detects hits, merges CPU word writes into lines, evicts dirty victims and refills lines.
//   On reset it sweeps all 32 entries to invalid, because the SRAM arrays are not reset.
// PARAMETERS
//   ADDR_W   32   CPU/memory byte-address width
//   INDEX_W  5    SRAM index bits (32 lines)
//   TAG_W    22   tag bits = ADDR_W-INDEX_W-5
//   LINE_W   256  line width (8 words, 32 bytes)
//   WORD_W   32   CPU word width
// PORTS
//   clock_i        in   1        clock, rising edge
//   rst_i          in   1        asynchronous active-high reset
//   req_i          in   1        CPU access request (held until stall_o low)
//   we_i           in   1        1=store, 0=load
//   addr_i         in   ADDR_W   byte address: tag[31:10] index[9:5] word[4:2]; bits [1:0] ignored
//   wdata_i        in   WORD_W   store data
//   rdata_o        out  WORD_W   load data, valid when req_i & ~we_i & ~stall_o
//   stall_o        out  1        CPU must hold request and pipeline
//   sram_enable_o  out  1        SRAM enable
//   sram_write_o   out  1        SRAM write strobe
//   sram_index_o   out  INDEX_W  SRAM index
//   sram_valid_o   out  1        SRAM write valid
//   sram_dirty_o   out  1        SRAM write dirty
//   sram_tag_o     out  TAG_W    SRAM write tag
//   sram_data_o    out  LINE_W   SRAM write data
//   sram_valid_i   in   1        SRAM read valid
//   sram_dirty_i   in   1        SRAM read dirty
//   sram_tag_i     in   TAG_W    SRAM read tag
//   sram_data_i    in   LINE_W   SRAM read data
//   mem_req_o      out  1        memory request, held until mem_ack_i
//   mem_we_o       out  1        1=write back line, 0=fetch line
//   mem_addr_o     out  ADDR_W   line-aligned address ([4:0]=0)
//   mem_data_o     out  LINE_W   victim line for write-back
//   mem_ack_i      in   1        one-cycle completion pulse; mem_data_i valid in same cycle
//   mem_data_i     in   LINE_W   fetched line
// BEHAVIOUR
//   - Reset (async): state=INIT, init counter=0.
//     All outputs 0 except stall_o=1 and the INIT-driven SRAM strobes.
//   - INIT, 32 cycles: sram_enable_o=sram_write_o=1, index=counter, valid=dirty=0, tag/data=0.
//     Counter wraps 31->0, then IDLE.
//     stall_o=1 throughout; req_i ignored.
//   - IDLE:
//     - sram_enable_o=1, index=addr_i[9:5].
//     - hit = req_i & sram_valid_i & (sram_tag_i==addr_i[31:10]).
//     - Load hit: rdata_o = word addr_i[4:2] of sram_data_i, combinational; stall_o=0 (0-cycle hit).
//     - Store hit: same cycle, sram_write_o=1, data = line with word[4:2] replaced by wdata_i.
//       Writes valid=1, dirty=1, and the unchanged tag; stall_o=0.
//     - Miss (req_i & ~hit): stall_o=1 combinationally.
//       Next state is WB when sram_valid_i & sram_dirty_i, else FETCH.
//       Latch the victim tag/line and the request address on that edge.
//     - No request: no SRAM write; stall_o=0.
//   - WB: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line.
//     Outputs stable until mem_ack_i; on ack go to FETCH.
//   - FETCH: mem_req_o=1, mem_we_o=0, mem_addr_o={addr_i[31:5], 5'b0}.
//     On mem_ack_i: write SRAM in the same cycle with valid=1, dirty=0, tag=addr_i[31:10],
//     data=mem_data_i. Then go to IDLE.
//   - Retry: back in IDLE the held request re-evaluates and hits.
//     A store then dirties the line, so the line is never written dirty-and-merged straight from FETCH.
//   - stall_o=1 in INIT, WB and FETCH, and in IDLE on a miss.
//   - mem_req_o deasserts in the cycle after ack. mem_ack_i outside WB/FETCH is ignored.
//   - req_i dropping during WB/FETCH is illegal (CPU holds while stalled); behaviour is undefined.
//   - Reset mid-operation aborts any memory transaction: mem_req_o=0 immediately, restart INIT.
//   - Memory latency is unbounded; no timeout.
// STRUCTURE
//   - Shared package dcache_pkg:
//     - state enum {INIT, IDLE, WB, FETCH}
//     - widths ADDR_W/INDEX_W/TAG_W/LINE_W/WORD_W
//     - functions addr_tag(), addr_index(), addr_word()
//   - Sub-module dcache_word_merge (combinational): line, word select, wdata -> merged line,
//     plus the word-extract mux. Everything else stays flat in one FSM plus victim/address registers.
// TESTING
//   1. Reset then idle: stall_o=1 for exactly 32 cycles, all 32 indices written valid=0, then stall_o=0.
//   2. Load 0x0000_0404 (cold): FETCH with mem_addr_o=0x0000_0400.
//      Ack with line word1=0xDEADBEEF -> next cycle rdata_o=0xDEADBEEF, stall_o=0, no mem write.
//   3. Store 0x0000_0408 <= 0x12345678 on that resident line -> 0 stall cycles.
//      SRAM write has dirty=1 and word2=0x12345678.
//   4. Load 0x0000_0808 (same index 0, tag differs, victim dirty) -> WB at 0x0000_0400 carrying
//      word2=0x12345678, then FETCH at 0x0000_0800, then hit.
//   5. Memory ack delayed 10 cycles in FETCH -> mem_req_o/mem_addr_o stable and stall_o=1 all 10 cycles.
//   6. Assert rst_i in the middle of WB -> mem_req_o=0 asynchronously, INIT restarts, stall_o=1 for 32 cycles.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the direct-mapped data cache controller.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int WSEL_W   = 3;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WB    = 2'd2,
    FETCH = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WSEL_W];
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Combinational word insert/extract on a cache line, indexed by the 3-bit word select.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] merged_line,
  output logic [WORD_W-1:0] rd_word
);

  logic [7:0] bit_base_s;

  assign bit_base_s = {word_sel, 5'd0};
  assign rd_word    = line[bit_base_s +: WORD_W];

  // Replace the selected word, keep the rest of the line
  always_comb begin
    merged_line = line;
    merged_line[bit_base_s +: WORD_W] = wdata;
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate, direct-mapped data cache controller driving a 32-line tag/data SRAM.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clock_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [INDEX_W-1:0] sram_index_o,
  output logic              sram_valid_o,
  output logic              sram_dirty_o,
  output logic [TAG_W-1:0]  sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  input  logic              sram_valid_i,
  input  logic              sram_dirty_i,
  input  logic [TAG_W-1:0]  sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i
);

  state_t              state_r, state_s;
  logic [INDEX_W-1:0]  init_cnt_r;
  logic [TAG_W-1:0]    victim_tag_r;
  logic [LINE_W-1:0]   victim_line_r;
  logic [ADDR_W-1:0]   req_addr_r;
  logic                hit_s, miss_s;
  logic [LINE_W-1:0]   merged_line_s;
  logic [WORD_W-1:0]   rd_word_s;

  assign hit_s  = req_i & sram_valid_i & (sram_tag_i == addr_tag(addr_i));
  assign miss_s = req_i & ~hit_s;

  dcache_word_merge u_word_merge (
    .line        (sram_data_i),
    .word_sel    (addr_word(addr_i)),
    .wdata       (wdata_i),
    .merged_line (merged_line_s),
    .rd_word     (rd_word_s)
  );

  // State, init sweep counter and miss-time capture of victim and request address
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= INIT;
      init_cnt_r    <= {INDEX_W{1'b0}};
      victim_tag_r  <= {TAG_W{1'b0}};
      victim_line_r <= {LINE_W{1'b0}};
      req_addr_r    <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == INIT) begin
        init_cnt_r <= init_cnt_r + 5'd1;
      end else begin
        init_cnt_r <= {INDEX_W{1'b0}};
      end
      if ((state_r == IDLE) && miss_s) begin
        victim_tag_r  <= sram_tag_i;
        victim_line_r <= sram_data_i;
        req_addr_r    <= addr_i;
      end
    end
  end

  // SRAM index kept apart from the main decode: it never depends on SRAM read data
  always_comb begin
    sram_index_o = {INDEX_W{1'b0}};
    case (state_r)
      INIT:     sram_index_o = init_cnt_r;
      IDLE:     sram_index_o = addr_index(addr_i);
      WB:       sram_index_o = addr_index(req_addr_r);
      FETCH:    sram_index_o = addr_index(req_addr_r);
      default:  sram_index_o = {INDEX_W{1'b0}};
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_s       = state_r;
    rdata_o       = {WORD_W{1'b0}};
    stall_o       = 1'b0;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_valid_o  = 1'b0;
    sram_dirty_o  = 1'b0;
    sram_tag_o    = {TAG_W{1'b0}};
    sram_data_o   = {LINE_W{1'b0}};
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = {ADDR_W{1'b0}};
    mem_data_o    = {LINE_W{1'b0}};
    case (state_r)
      INIT: begin
        stall_o       = 1'b1;
        sram_enable_o = 1'b1;
        sram_write_o  = 1'b1;
        if (init_cnt_r == 5'd31) begin
          state_s = IDLE;
        end else begin
          state_s = INIT;
        end
      end
      IDLE: begin
        sram_enable_o = 1'b1;
        if (miss_s) begin
          stall_o = 1'b1;
          if (sram_valid_i && sram_dirty_i) begin
            state_s = WB;
          end else begin
            state_s = FETCH;
          end
        end else if (req_i && we_i) begin
          sram_write_o = 1'b1;
          sram_valid_o = 1'b1;
          sram_dirty_o = 1'b1;
          sram_tag_o   = sram_tag_i;
          sram_data_o  = merged_line_s;
        end else if (req_i) begin
          rdata_o = rd_word_s;
        end else begin
          state_s = IDLE;
        end
      end
      WB: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {victim_tag_r, addr_index(req_addr_r), 5'd0};
        mem_data_o = victim_line_r;
        if (mem_ack_i) begin
          state_s = FETCH;
        end else begin
          state_s = WB;
        end
      end
      FETCH: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {req_addr_r[ADDR_W-1:OFFSET_W], 5'd0};
        if (mem_ack_i) begin
          // Refill lands clean; a pending store dirties it on the retry hit
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_valid_o  = 1'b1;
          sram_tag_o    = addr_tag(req_addr_r);
          sram_data_o   = mem_data_i;
          state_s       = IDLE;
        end else begin
          state_s = FETCH;
        end
      end
      default: begin
        stall_o = 1'b1;
        state_s = INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a behavioural SRAM and hand-driven memory.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req, we;
  logic [31:0]       addr, wdata, rdata;
  logic              stall;
  logic              s_en, s_wr, s_valid_o, s_dirty_o, s_valid_i, s_dirty_i;
  logic [4:0]        s_idx;
  logic [21:0]       s_tag_o, s_tag_i;
  logic [255:0]      s_data_o, s_data_i;
  logic              mem_req, mem_we, mem_ack;
  logic [31:0]       mem_addr;
  logic [255:0]      mem_data_o, mem_data_i;

  logic              m_valid [32];
  logic              m_dirty [32];
  logic [21:0]       m_tag   [32];
  logic [255:0]      m_data  [32];
  int                wr_cnt, wb_cnt;
  logic [31:0]       wr_mask;
  logic              init_bad;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                cnt;
  logic [255:0]      line_a, line_a2, line_b, line_b0, line_c, line_c7;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clock_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .stall_o(stall),
    .sram_enable_o(s_en), .sram_write_o(s_wr), .sram_index_o(s_idx), .sram_valid_o(s_valid_o),
    .sram_dirty_o(s_dirty_o), .sram_tag_o(s_tag_o), .sram_data_o(s_data_o),
    .sram_valid_i(s_valid_i), .sram_dirty_i(s_dirty_i), .sram_tag_i(s_tag_i), .sram_data_i(s_data_i),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack), .mem_data_i(mem_data_i)
  );

  assign s_valid_i = m_valid[s_idx];
  assign s_dirty_i = m_dirty[s_idx];
  assign s_tag_i   = m_tag[s_idx];
  assign s_data_i  = m_data[s_idx];

  // Behavioural SRAM plus write/write-back bookkeeping
  always @(posedge clk) begin
    if (s_en && s_wr) begin
      m_valid[s_idx] <= s_valid_o;
      m_dirty[s_idx] <= s_dirty_o;
      m_tag[s_idx]   <= s_tag_o;
      m_data[s_idx]  <= s_data_o;
    end
    if (rst) begin
      wr_cnt   <= 0;
      wb_cnt   <= 0;
      wr_mask  <= 32'd0;
      init_bad <= 1'b0;
    end else begin
      if (s_en && s_wr) begin
        wr_cnt         <= wr_cnt + 1;
        wr_mask[s_idx] <= 1'b1;
        if (wr_cnt < 32 && (s_valid_o || s_dirty_o || s_tag_o != 22'd0 || s_data_o != 256'd0))
          init_bad <= 1'b1;
      end
      if (mem_req && mem_we && mem_ack) wb_cnt <= wb_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_init_sweep(input string tag);
    logic any_valid;
    cnt = 0;
    while (stall && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check_eq({tag, "_stall_cycles"}, cnt, 32);
    check_eq({tag, "_sram_writes"}, wr_cnt, 32);
    check_eq({tag, "_index_mask"}, wr_mask, 32'hFFFF_FFFF);
    check_eq({tag, "_zero_fields"}, init_bad, 1'b0);
    any_valid = 1'b0;
    for (int i = 0; i < 32; i++) any_valid |= m_valid[i];
    check_eq({tag, "_all_invalid"}, any_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      line_a[i*32 +: 32] = 32'hA000_0000 + i;
      line_b[i*32 +: 32] = 32'hB000_0000 + i;
      line_c[i*32 +: 32] = 32'hC000_0000 + i;
    end
    line_a[63:32]   = 32'hDEAD_BEEF;
    line_a2         = line_a;
    line_a2[95:64]  = 32'h1234_5678;
    line_b0         = line_b;
    line_b0[31:0]   = 32'hCAFE_F00D;
    line_c7         = line_c;
    line_c7[255:224] = 32'h55AA_55AA;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    mem_ack = 1'b0; mem_data_i = 256'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_stall", stall, 1'b1);
    check_eq("reset_mem_req", mem_req, 1'b0);
    check_eq("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    check_init_sweep("init1");
    check_eq("idle_stall", stall, 1'b0);

    // Cold load miss, clean victim -> direct fetch
    req = 1'b1; we = 1'b0; addr = 32'h0000_0404;
    #1 check_eq("cold_miss_stall", stall, 1'b1);
    @(negedge clk);
    check_eq("fetch1_req", mem_req, 1'b1);
    check_eq("fetch1_we", mem_we, 1'b0);
    check_eq("fetch1_addr", mem_addr, 32'h0000_0400);
    mem_ack = 1'b1; mem_data_i = line_a;
    @(negedge clk);
    mem_ack = 1'b0; mem_data_i = 256'd0;
    #1 check_eq("load_hit_stall", stall, 1'b0);
    check_eq("load_hit_rdata", rdata, 32'hDEAD_BEEF);
    check_eq("load_mem_req_drop", mem_req, 1'b0);
    check_eq("load_no_wb", wb_cnt, 0);

    // Store hit merges word 2 in the same cycle
    we = 1'b1; addr = 32'h0000_0408; wdata = 32'h1234_5678;
    #1 check_eq("store_hit_stall", stall, 1'b0);
    check_eq("store_sram_write", s_wr, 1'b1);
    check_eq("store_sram_dirty", s_dirty_o, 1'b1);
    check_eq("store_sram_valid", s_valid_o, 1'b1);
    check_eq("store_sram_tag", s_tag_o, 22'd1);
    check_eq("store_sram_data", s_data_o, line_a2);

    // Conflict miss on a dirty victim -> write-back, then fetch with a slow ack
    @(negedge clk);
    we = 1'b0; addr = 32'h0000_0808;
    #1 check_eq("conflict_stall", stall, 1'b1);
    @(negedge clk);
    check_eq("wb_we", mem_we, 1'b1);
    check_eq("wb_addr", mem_addr, 32'h0000_0400);
    check_eq("wb_data", mem_data_o, line_a2);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("slow_fetch_req", mem_req, 1'b1);
      check_eq("slow_fetch_we", mem_we, 1'b0);
      check_eq("slow_fetch_addr", mem_addr, 32'h0000_0800);
      check_eq("slow_fetch_stall", stall, 1'b1);
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_data_i = line_b;
    @(negedge clk);
    mem_ack = 1'b0; mem_data_i = 256'd0;
    #1 check_eq("refill_hit_stall", stall, 1'b0);
    check_eq("refill_hit_rdata", rdata, 32'hB000_0002);
    check_eq("refill_clean", m_dirty[0], 1'b0);
    check_eq("refill_tag", m_tag[0], 22'd2);
    check_eq("wb_count", wb_cnt, 1);

    // Stray ack with no request is ignored
    req = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check_eq("stray_ack_mem_req", mem_req, 1'b0);
    check_eq("stray_ack_stall", stall, 1'b0);

    // Dirty the line, miss again, then reset in the middle of the write-back
    req = 1'b1; we = 1'b1; addr = 32'h0000_0800; wdata = 32'hCAFE_F00D;
    #1 check_eq("store2_stall", stall, 1'b0);
    @(negedge clk);
    we = 1'b0; addr = 32'h0000_0404;
    #1 check_eq("miss2_stall", stall, 1'b1);
    @(negedge clk);
    check_eq("wb2_addr", mem_addr, 32'h0000_0800);
    check_eq("wb2_data", mem_data_o, line_b0);
    rst = 1'b1;
    #1 check_eq("async_rst_mem_req", mem_req, 1'b0);
    check_eq("async_rst_stall", stall, 1'b1);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    check_init_sweep("init2");

    // Boundary line and word: index 31, word 7
    req = 1'b1; we = 1'b0; addr = 32'h0000_03FC;
    #1 check_eq("idx31_miss_stall", stall, 1'b1);
    @(negedge clk);
    check_eq("idx31_fetch_addr", mem_addr, 32'h0000_03E0);
    mem_ack = 1'b1; mem_data_i = line_c;
    @(negedge clk);
    mem_ack = 1'b0; mem_data_i = 256'd0;
    #1 check_eq("idx31_rdata", rdata, 32'hC000_0007);
    we = 1'b1; wdata = 32'h55AA_55AA;
    #1 check_eq("idx31_store_stall", stall, 1'b0);
    check_eq("idx31_store_index", s_idx, 5'd31);
    check_eq("idx31_store_data", s_data_o, line_c7);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    #1 check_eq("noreq_sram_write", s_wr, 1'b0);
    check_eq("idx31_stored_word", m_data[31], line_c7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
